// File: rtl/nbit_execute_unit.sv
`default_nettype none
// ============================================================================
// Module   : nbit_execute_unit
// Brief    : Execute stage feeding the register-file write port; single-cycle
//            ALU ops plus an iterative shift-add multiplier with Busy handshake.
// Revision : 1.0
// ============================================================================
module nbit_execute_unit #(
    parameter int REG_SELECT_WIDTH = 5,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                        Clk_i,
    input  logic                        Reset_ni,
    input  logic                        Start_i,
    input  logic [2:0]                  OpCode_i,
    input  logic [DATA_WIDTH-1:0]       OperandA_i,
    input  logic [DATA_WIDTH-1:0]       OperandB_i,
    input  logic [REG_SELECT_WIDTH-1:0] DestSelect_i,
    output logic                        Busy_o,
    output logic [DATA_WIDTH-1:0]       WriteData_o,
    output logic [REG_SELECT_WIDTH-1:0] WriteSelect_o,
    output logic                        WriteEnable_o,
    output logic                        Overflow_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int MSB   = DATA_WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic [2*DATA_WIDTH-1:0]       mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]         mplier_q, mplier_d;
    logic [2*DATA_WIDTH-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [REG_SELECT_WIDTH-1:0]   dest_q, dest_d;
    logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
    logic [REG_SELECT_WIDTH-1:0]   wsel_q, wsel_d;
    logic                          we_q, we_d;
    logic                          ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0]         add_res;
    logic [DATA_WIDTH-1:0]         sub_res;
    logic                          add_ovf;
    logic                          sub_ovf;
    logic                          slt_res;
    logic [2*DATA_WIDTH-1:0]       acc_sum;

    assign add_res = OperandA_i + OperandB_i;
    assign sub_res = OperandA_i - OperandB_i;
    // Signed overflow: operand signs agree (ADD) / differ (SUB) but the result sign flips
    assign add_ovf = (OperandA_i[MSB] == OperandB_i[MSB]) && (add_res[MSB] != OperandA_i[MSB]);
    assign sub_ovf = (OperandA_i[MSB] != OperandB_i[MSB]) && (sub_res[MSB] != OperandA_i[MSB]);
    assign slt_res = $signed(OperandA_i) < $signed(OperandB_i);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        dest_d   = dest_q;
        wdata_d  = wdata_q;
        wsel_d   = wsel_q;
        we_d     = 1'b0;
        ovf_d    = ovf_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            S_IDLE: begin
                if (Start_i) begin
                    case (OpCode_i)
                        OP_ADD: begin wdata_d = add_res; ovf_d = add_ovf; we_d = 1'b1; end
                        OP_SUB: begin wdata_d = sub_res; ovf_d = sub_ovf; we_d = 1'b1; end
                        OP_AND: begin wdata_d = OperandA_i & OperandB_i; ovf_d = 1'b0; we_d = 1'b1; end
                        OP_OR:  begin wdata_d = OperandA_i | OperandB_i; ovf_d = 1'b0; we_d = 1'b1; end
                        OP_XOR: begin wdata_d = OperandA_i ^ OperandB_i; ovf_d = 1'b0; we_d = 1'b1; end
                        OP_SLT: begin
                            wdata_d = {{(DATA_WIDTH-1){1'b0}}, slt_res};
                            ovf_d   = 1'b0;
                            we_d    = 1'b1;
                        end
                        OP_MUL: begin
                            mcand_d  = {{DATA_WIDTH{1'b0}}, OperandA_i};
                            mplier_d = OperandB_i;
                            acc_d    = '0;
                            count_d  = CNT_W'(DATA_WIDTH);
                            dest_d   = DestSelect_i;
                            state_d  = S_MUL;
                        end
                        default: ;
                    endcase
                    if (we_d) begin
                        wsel_d = DestSelect_i;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CNT_W'(1);
                // Last step: publish the accumulator including this edge's partial product
                if (count_q == CNT_W'(1)) begin
                    wdata_d = acc_sum[DATA_WIDTH-1:0];
                    ovf_d   = |acc_sum[2*DATA_WIDTH-1:DATA_WIDTH];
                    wsel_d  = dest_q;
                    we_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            dest_q   <= '0;
            wdata_q  <= '0;
            wsel_q   <= '0;
            we_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            dest_q   <= dest_d;
            wdata_q  <= wdata_d;
            wsel_q   <= wsel_d;
            we_q     <= we_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Busy_o        = (state_q == S_MUL);
    assign WriteData_o   = wdata_q;
    assign WriteSelect_o = wsel_q;
    assign WriteEnable_o = we_q;
    assign Overflow_o    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nbit_execute_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbit_execute_unit
// Brief    : Self-checking bench for nbit_execute_unit against an arithmetic
//            reference model, with a register-file model on the write port.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_nbit_execute_unit;

    localparam int RSW = 5;
    localparam int DW  = 32;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           Start;
    logic [2:0]     OpCode;
    logic [DW-1:0]  OpA, OpB;
    logic [RSW-1:0] Dest;
    logic           Busy;
    logic [DW-1:0]  WData;
    logic [RSW-1:0] WSel;
    logic           WE;
    logic           Ovf;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] regs [2**RSW];

    always #5 Clk = ~Clk;

    nbit_execute_unit #(
        .REG_SELECT_WIDTH(RSW),
        .DATA_WIDTH      (DW)
    ) dut (
        .Clk_i        (Clk),
        .Reset_ni     (Reset_n),
        .Start_i      (Start),
        .OpCode_i     (OpCode),
        .OperandA_i   (OpA),
        .OperandB_i   (OpB),
        .DestSelect_i (Dest),
        .Busy_o       (Busy),
        .WriteData_o  (WData),
        .WriteSelect_o(WSel),
        .WriteEnable_o(WE),
        .Overflow_o   (Ovf)
    );

    // Register file sitting on the write port
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 2**RSW; i++) regs[i] <= 32'hA5A5_0000 + DW'(i);
        end else if (WE) begin
            regs[WSel] <= WData;
        end
    end

    function automatic void ref_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   output logic [DW-1:0] r, output logic ovf, output logic valid);
        longint          sa, sb, s, maxs, mins;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        maxs = (longint'(1) << (DW-1)) - 1;
        mins = -(longint'(1) << (DW-1));
        r = '0; ovf = 1'b0; valid = 1'b1;
        case (op)
            3'd0: begin s = sa + sb; r = DW'(s); ovf = (s > maxs) || (s < mins); end
            3'd1: begin s = sa - sb; r = DW'(s); ovf = (s > maxs) || (s < mins); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? DW'(1) : DW'(0);
            3'd6: begin p = ua * ub; r = DW'(p); ovf = (p >> DW) != 0; end
            default: valid = 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return {1'b0, {(DW-1){1'b1}}};
            2: return {1'b1, {(DW-1){1'b0}}};
            3: return '1;
            4: return DW'(1);
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [RSW-1:0] d);
        Start = 1'b1; OpCode = op; OpA = a; OpB = b; Dest = d;
    endtask

    // Issues a MUL and observes DW+8 cycles; optionally raises an ADD 1+1 -> r2 at cycle inj
    task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [RSW-1:0] d,
                           input int inj, output int busy_cnt, output int we_cnt, output int we_at,
                           output logic busy_at_we, output logic [DW-1:0] dat, output logic [RSW-1:0] sel,
                           output logic ovf, output logic [DW-1:0] last_dat);
        busy_cnt = 0; we_cnt = 0; we_at = -1; busy_at_we = 1'b1;
        dat = '0; sel = '0; ovf = 1'b0; last_dat = '0;
        @(negedge Clk);
        drive(3'd6, a, b, d);
        for (int c = 1; c <= DW + 8; c++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (c == inj) drive(3'd0, DW'(1), DW'(1), RSW'(2));
            if (Busy) busy_cnt++;
            if (WE) begin
                if (we_cnt == 0) begin
                    we_at = c; busy_at_we = Busy; dat = WData; sel = WSel; ovf = Ovf;
                end
                last_dat = WData;
                we_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Start = 1'b0; OpCode = '0; OpA = '0; OpB = '0; Dest = '0;
        #1;
        checks++; if ({Busy, WE, Ovf} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got busy/we/ovf=%b expected 000", {Busy, WE, Ovf}); end
        checks++; if ({WData, WSel} !== '0) begin errors++;
            $display("FAIL reset_data: got data=%h sel=%0d expected 0/0", WData, WSel); end
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        @(negedge Clk); drive(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3);
        @(negedge Clk); Start = 1'b0;
        checks++; if ({WE, Ovf, WSel, WData} !== {1'b1, 1'b1, 5'd3, 32'h8000_0000}) begin errors++;
            $display("FAIL add_ovf: got we=%b ovf=%b sel=%0d data=%h expected 1 1 3 80000000", WE, Ovf, WSel, WData); end
        @(negedge Clk);
        checks++; if ({WE, WData} !== {1'b0, 32'h8000_0000}) begin errors++;
            $display("FAIL add_pulse_end: got we=%b data=%h expected 0 80000000 (held)", WE, WData); end
    endtask

    task automatic test_back_to_back();
        @(negedge Clk); drive(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10);
        @(negedge Clk); drive(3'd1, 32'd5, 32'd7, 5'd11);
        checks++; if ({WE, Ovf, WSel, WData} !== {1'b1, 1'b0, 5'd10, 32'd1}) begin errors++;
            $display("FAIL b2b_slt: got we=%b ovf=%b sel=%0d data=%h expected 1 0 10 00000001", WE, Ovf, WSel, WData); end
        @(negedge Clk); Start = 1'b0;
        checks++; if ({WE, Ovf, WSel, WData} !== {1'b1, 1'b0, 5'd11, 32'hFFFF_FFFE}) begin errors++;
            $display("FAIL b2b_sub: got we=%b ovf=%b sel=%0d data=%h expected 1 0 11 fffffffe", WE, Ovf, WSel, WData); end
        @(negedge Clk);
        checks++; if (WE !== 1'b0) begin errors++;
            $display("FAIL b2b_end: got we=%b expected 0", WE); end
    endtask

    task automatic test_random_alu();
        logic [DW-1:0]  exp_d, last_d;
        logic [RSW-1:0] exp_s, last_s;
        logic           exp_o, exp_v;
        logic [2:0]     op;
        logic [DW-1:0]  a, b;
        logic [RSW-1:0] d;
        last_d = WData; last_s = WSel;
        exp_d = '0; exp_s = '0; exp_o = 1'b0; exp_v = 1'b0;
        for (int i = 0; i <= 24; i++) begin
            @(negedge Clk);
            if (i > 0) begin
                checks++;
                if (exp_v) begin
                    if ({WE, Ovf, WSel, WData} !== {1'b1, exp_o, exp_s, exp_d}) begin errors++;
                        $display("FAIL rand_alu[%0d]: got we=%b ovf=%b sel=%0d data=%h expected 1 %b %0d %h",
                                 i, WE, Ovf, WSel, WData, exp_o, exp_s, exp_d); end
                    last_d = exp_d; last_s = exp_s;
                end else begin
                    if ({WE, WSel, WData} !== {1'b0, last_s, last_d}) begin errors++;
                        $display("FAIL rand_rsvd[%0d]: got we=%b sel=%0d data=%h expected 0 %0d %h",
                                 i, WE, WSel, WData, last_s, last_d); end
                end
            end
            if (i < 24) begin
                op = 3'($urandom_range(0, 6));
                if (op == 3'd6) op = 3'd7;
                a = rand_operand(); b = rand_operand(); d = RSW'($urandom);
                ref_op(op, a, b, exp_d, exp_o, exp_v);
                exp_s = d;
                drive(op, a, b, d);
            end else begin
                Start = 1'b0;
            end
        end
    endtask

    task automatic test_mul_basic();
        int bc, wc, wa; logic bw, o; logic [DW-1:0] dt, ld; logic [RSW-1:0] s;
        run_mul(32'd7, 32'd6, 5'd9, -1, bc, wc, wa, bw, dt, s, o, ld);
        checks++; if (bc !== DW) begin errors++;
            $display("FAIL mul_busy_len: got %0d expected %0d", bc, DW); end
        checks++; if ({wc, wa} !== {32'd1, 32'(DW + 1)}) begin errors++;
            $display("FAIL mul_pulse: got count=%0d at=%0d expected 1 at %0d", wc, wa, DW + 1); end
        checks++; if ({bw, o, s, dt} !== {1'b0, 1'b0, 5'd9, 32'd42}) begin errors++;
            $display("FAIL mul_result: got busy=%b ovf=%b sel=%0d data=%h expected 0 0 9 0000002a", bw, o, s, dt); end
    endtask

    task automatic test_mul_ignored_start();
        int bc, wc, wa; logic bw, o; logic [DW-1:0] dt, ld; logic [RSW-1:0] s;
        run_mul(32'h0001_0000, 32'h0001_0000, 5'd5, 10, bc, wc, wa, bw, dt, s, o, ld);
        checks++; if ({wc, wa} !== {32'd1, 32'(DW + 1)}) begin errors++;
            $display("FAIL mul_ignore_pulse: got count=%0d at=%0d expected 1 at %0d", wc, wa, DW + 1); end
        checks++; if ({o, s, dt} !== {1'b1, 5'd5, 32'd0}) begin errors++;
            $display("FAIL mul_ovf: got ovf=%b sel=%0d data=%h expected 1 5 00000000", o, s, dt); end
    endtask

    task automatic test_mul_then_add();
        int bc, wc, wa; logic bw, o; logic [DW-1:0] dt, ld; logic [RSW-1:0] s;
        run_mul(32'd3, 32'd5, 5'd6, DW + 1, bc, wc, wa, bw, dt, s, o, ld);
        checks++; if ({wc, wa, dt, ld} !== {32'd2, 32'(DW + 1), 32'd15, 32'd2}) begin errors++;
            $display("FAIL mul_then_add: got count=%0d at=%0d mul=%h add=%h expected 2 %0d 0000000f 00000002",
                     wc, wa, dt, ld, DW + 1); end
        checks++; if (WSel !== 5'd2) begin errors++;
            $display("FAIL mul_then_add_sel: got %0d expected 2", WSel); end
    endtask

    task automatic test_random_mul();
        int bc, wc, wa; logic bw, o, eo, ev; logic [DW-1:0] dt, ld, a, b, ed; logic [RSW-1:0] s, d;
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 0) ? DW'($urandom_range(0, 65535)) : DW'($urandom);
            b = (i < 2) ? DW'($urandom_range(0, 65535)) : DW'($urandom);
            d = RSW'($urandom);
            ref_op(3'd6, a, b, ed, eo, ev);
            run_mul(a, b, d, -1, bc, wc, wa, bw, dt, s, o, ld);
            checks++; if ({wc, wa, bc, o, s, dt} !== {32'd1, 32'(DW + 1), 32'(DW), eo, d, ed}) begin errors++;
                $display("FAIL rand_mul[%0d] %h*%h: got cnt=%0d at=%0d busy=%0d ovf=%b sel=%0d data=%h expected ovf=%b sel=%0d data=%h",
                         i, a, b, wc, wa, bc, o, s, dt, eo, d, ed); end
        end
    endtask

    task automatic test_reset_abort();
        int wc;
        @(negedge Clk); drive(3'd0, 32'd5, 32'd6, 5'd7);
        @(negedge Clk); drive(3'd6, 32'd3, 32'd3, 5'd12);
        for (int c = 1; c < 10; c++) begin
            @(negedge Clk); Start = 1'b0;
        end
        checks++; if (Busy !== 1'b1) begin errors++;
            $display("FAIL abort_busy_before: got %b expected 1", Busy); end
        @(negedge Clk); #2 Reset_n = 1'b0; #1;
        checks++; if ({Busy, WE, Ovf, WSel, WData} !== '0) begin errors++;
            $display("FAIL abort_async: got busy=%b we=%b ovf=%b sel=%0d data=%h expected all 0", Busy, WE, Ovf, WSel, WData); end
        @(negedge Clk); Reset_n = 1'b1;
        wc = 0;
        for (int c = 0; c < DW + 8; c++) begin
            @(negedge Clk);
            if (WE || Busy) wc++;
        end
        checks++; if (wc !== 0) begin errors++;
            $display("FAIL abort_no_write: got %0d active cycles expected 0", wc); end
        drive(3'd0, 32'd2, 32'd2, 5'd1);
        @(negedge Clk); Start = 1'b0;
        checks++; if ({WE, WSel, WData} !== {1'b1, 5'd1, 32'd4}) begin errors++;
            $display("FAIL abort_then_add: got we=%b sel=%0d data=%h expected 1 1 00000004", WE, WSel, WData); end
    endtask

    task automatic test_reserved();
        logic [DW-1:0] snap_r, snap_d;
        int act;
        @(negedge Clk);
        snap_r = regs[4]; snap_d = WData; act = 0;
        drive(3'd7, 32'h1234, 32'h5678, 5'd4);
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk); Start = 1'b0;
            if (WE || Busy) act++;
        end
        checks++; if (act !== 0) begin errors++;
            $display("FAIL rsvd_activity: got %0d we/busy cycles expected 0", act); end
        checks++; if ({regs[4], WData} !== {snap_r, snap_d}) begin errors++;
            $display("FAIL rsvd_state: got reg4=%h data=%h expected %h %h", regs[4], WData, snap_r, snap_d); end
    endtask

    initial begin
        #200us;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_random_alu();
        test_mul_basic();
        test_mul_ignored_start();
        test_mul_then_add();
        test_random_mul();
        test_reset_abort();
        test_reserved();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
